ens_vote_argmax: RTL and testbench
==================================

ENS_VOTE_ARGMAX -- requirements
Module: ens_vote_argmax

Interface
REQ-001 SHALL have parameter NUM_ENS, default 4: ensemble members (beats) per vote; legal range 2-16.
REQ-002 SHALL have parameter NUM_CLASSES, default 10: number of output classes.
REQ-003 SHALL have parameter SCORE_W, default 2: unsigned per-class score width from one ensemble member's final neuron layer.
REQ-004 SHALL derive ACC_W = SCORE_W + clog2(NUM_ENS), which is 4 at defaults, and IDX_W = clog2(NUM_CLASSES), which is 4 at defaults.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit: an ensemble score vector is present.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a beat.
REQ-009 SHALL have port in_data, input, NUM_CLASSES*SCORE_W bits: class c score in in_data[c*SCORE_W +: SCORE_W].
REQ-010 SHALL have port out_valid, output, 1 bit: a vote result is present.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port out_class, output, IDX_W bits: the winning class index.
REQ-013 SHALL have port out_score, output, ACC_W bits: the winning accumulated score.

Function
REQ-014 SHALL implement a three-state FSM: ACCUM, ARGMAX, OUT.
REQ-015 In ACCUM:
- in_ready=1 and out_valid=0.
- A beat transfers on a rising edge with in_valid=1 and in_ready=1.
REQ-016 Beat accumulation:
- The first beat of a vote (beat count 0) SHALL load acc[c] with the zero-extended score.
- Each later beat SHALL add the zero-extended score to acc[c].
- Width ACC_W; overflow is impossible by construction.
REQ-017 Beat counter:
- SHALL increment on every transfer.
- On the transfer where the count equals NUM_ENS-1, SHALL clear to 0 and move the FSM to ARGMAX.
REQ-018 In ARGMAX:
- in_ready=0, out_valid=0.
- Exactly one class is examined per cycle, index i=0 to NUM_CLASSES-1.
- At i=0, best=acc[0] and best_idx=0.
- For i>0, best and best_idx update only if acc[i] > best (strict), so ties resolve to the lowest index.
REQ-019 After the edge examining class NUM_CLASSES-1, the FSM SHALL enter OUT. out_valid rises exactly NUM_CLASSES rising edges after the edge that accepted the final beat.
REQ-020 In OUT:
- out_valid=1, in_ready=0.
- out_class=best_idx and out_score=best, held stable until a transfer.
REQ-021 An out_valid=1 and out_ready=1 edge SHALL complete the result transfer and return the FSM to ACCUM. in_ready rises in the following cycle; there is no combinational ready path from out_ready to in_ready.
REQ-022 out_valid SHALL NOT drop without a transfer. in_valid with in_ready=0 SHALL be ignored; the upstream holds it.
REQ-023 in_ready and out_valid SHALL be driven directly from the FSM state register.

Reset
REQ-024 While rst_n=0, the block SHALL immediately:
- Force the FSM to ACCUM with in_ready=1 and out_valid=0.
- Set out_class=0 and out_score=0.
- Set the beat counter, ARGMAX index, all acc[c] and best to 0.
REQ-025 Reset asserted mid-vote or mid-ARGMAX SHALL discard all partial state. The first beat after reset release starts a new vote.
REQ-026 Reset release SHALL be synchronised externally. The block needs no internal reset synchroniser.

Verification (NUM_ENS=4, NUM_CLASSES=10, SCORE_W=2)
REQ-027 Reset: pulse rst_n low mid-cycle -> out_valid=0, in_ready=1, out_class=0 immediately, without waiting for a clock edge.
REQ-028 Basic vote: 4 beats, class 3 score=3, others 0 -> out_valid exactly 10 edges after the 4th accept; out_class=3, out_score=12.
REQ-029 Tie: class 2 and class 7 each total 9, others below -> out_class=2, out_score=9.
REQ-030 Backpressure:
- Hold out_ready=0 for 5 cycles in OUT -> out_valid, out_class and out_score stay stable, and in_ready=0 throughout.
- Raise out_ready -> one transfer, then in_ready=1 the next cycle.
REQ-031 Abort: 2 beats of all-3, assert rst_n=0, then 4 beats where only class 5 score=1 -> out_class=5, out_score=4; no residue from the aborted vote.
REQ-032 Extremes:
- All beats all-zero -> out_class=0, out_score=0.
- All beats all-3 -> out_class=0, out_score=12.
- Back-to-back votes with in_valid held high -> 4 transfers per vote, none during ARGMAX or OUT.

Source files
------------

// File: rtl/ens_vote_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : ens_vote_argmax
//  Purpose  : Accumulates NUM_ENS per-class score vectors (one per ensemble
//             member), then scans the class totals one per cycle and returns
//             the index and total of the highest-scoring class. Ties resolve
//             to the lowest class index.
//  Revision : 1.0 - initial release
// ============================================================================
module ens_vote_argmax #(
    parameter  int NUM_ENS     = 4,
    parameter  int NUM_CLASSES = 10,
    parameter  int SCORE_W     = 2,
    localparam int ACC_W       = SCORE_W + $clog2(NUM_ENS),
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CLASSES*SCORE_W-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [IDX_W-1:0]               out_class,
    output logic [ACC_W-1:0]               out_score
);

    localparam int             CNT_W    = $clog2(NUM_ENS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_ENS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ARGMAX = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   idx_q,      idx_d;
    logic [ACC_W-1:0]   best_q,     best_d;
    logic [IDX_W-1:0]   best_idx_q, best_idx_d;
    logic [ACC_W-1:0]   acc_q [NUM_CLASSES];
    logic [ACC_W-1:0]   acc_d [NUM_CLASSES];

    logic [ACC_W-1:0]   score_ext [NUM_CLASSES];
    logic [ACC_W-1:0]   acc_sel;

    // Slice each class score out of the input bus, zero-extended to ACC_W.
    generate
        for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_score
            assign score_ext[c] = ACC_W'(in_data[c*SCORE_W +: SCORE_W]);
        end
    endgenerate

    // Class total currently under examination by the argmax scan.
    assign acc_sel = acc_q[idx_q];

    // Handshake flags decode straight from the state register.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUT);
    assign out_class = best_idx_q;
    assign out_score = best_q;

    // Next-state and datapath update for accumulate / scan / present phases.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        idx_d      = idx_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        acc_d      = acc_q;

        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    // The first beat overwrites, so a new vote never sees
                    // totals from the previous one.
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        if (beat_cnt_q == '0) begin
                            acc_d[c] = score_ext[c];
                        end else begin
                            acc_d[c] = acc_q[c] + score_ext[c];
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        state_d    = ST_ARGMAX;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_ARGMAX: begin
                // Strict compare keeps the earliest class on a tie.
                if (idx_q == '0) begin
                    best_d     = acc_sel;
                    best_idx_d = '0;
                end else if (acc_sel > best_q) begin
                    best_d     = acc_sel;
                    best_idx_d = idx_q;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end
            end

            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and datapath registers; reset clears every partial result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ACCUM;
            beat_cnt_q <= '0;
            idx_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            idx_q      <= idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            for (int c = 0; c < NUM_CLASSES; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ens_vote_argmax.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ens_vote_argmax
//  Purpose  : Directed self-checking bench for ens_vote_argmax at default
//             parameters (4 members, 10 classes, 2-bit scores).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ens_vote_argmax;

    localparam int NUM_ENS     = 4;
    localparam int NUM_CLASSES = 10;
    localparam int SCORE_W     = 2;
    localparam int DW          = NUM_CLASSES * SCORE_W;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_class;
    logic [3:0]    out_score;

    int checks = 0;
    int errors = 0;

    // Transfer counters and last-result capture, maintained by a monitor.
    int         in_xfers  = 0;
    int         out_xfers = 0;
    logic [3:0] last_class = '0;
    logic [3:0] last_score = '0;

    ens_vote_argmax #(
        .NUM_ENS     (NUM_ENS),
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshakes seen on each rising edge.
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) in_xfers <= in_xfers + 1;
        if (rst_n && out_valid && out_ready) begin
            out_xfers  <= out_xfers + 1;
            last_class <= out_class;
            last_score <= out_score;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat (called at a falling edge); returns at the falling
    // edge after the rising edge that accepted it.
    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("beat_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_vote(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                             input logic [DW-1:0] b2, input logic [DW-1:0] b3);
        send_beat(b0);
        send_beat(b1);
        send_beat(b2);
        send_beat(b3);
    endtask

    // Counts falling edges until out_valid, bounded.
    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, n, 10);
    endtask

    // Check the presented result, optionally stall, then accept it.
    task automatic take(input string tag, input logic [3:0] cls, input logic [3:0] scr, input int hold);
        int o0;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_score"}, out_score, scr);
        check({tag, "_in_ready_low"}, in_ready, 1'b0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_state"}, {out_valid, in_ready, out_class, out_score}, {1'b1, 1'b0, cls, scr});
        end
        o0        = out_xfers;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_one_xfer"}, out_xfers - o0, 1);
        check({tag, "_after_xfer"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int i0;
        int o0;
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset_state", {out_valid, in_ready, out_class, out_score}, {1'b1 ^ 1'b1, 1'b1, 4'd0, 4'd0});
        rst_n = 1'b1;
        @(negedge clk);

        // Basic vote: class 3 scores 3 on every beat
        send_vote(20'h000C0, 20'h000C0, 20'h000C0, 20'h000C0);
        check("basic_no_early_valid", out_valid, 1'b0);
        wait_out("basic_latency");
        take("basic", 4'd3, 4'd12, 0);

        // Same vote again; asynchronous reset pulse while the result is held
        send_vote(20'h000C0, 20'h000C0, 20'h000C0, 20'h000C0);
        wait_out("rst_vote_latency");
        check("rst_vote_class", out_class, 4'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, in_ready, out_class, out_score}, {1'b0, 1'b1, 4'd0, 4'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Tie: classes 2 and 7 total 9, class 9 totals 8
        send_vote(20'h8C030, 20'h8C030, 20'h8C030, 20'h80000);
        wait_out("tie_latency");
        take("tie", 4'd2, 4'd9, 0);

        // Backpressure: class 6 totals 7, class 1 totals 4; stray in_valid
        // during the stall must be ignored
        send_vote(20'h01004, 20'h02004, 20'h03004, 20'h01004);
        wait_out("bp_latency");
        i0       = in_xfers;
        in_valid = 1'b1;
        in_data  = 20'hFFFFF;
        take("bp", 4'd6, 4'd7, 5);
        in_valid = 1'b0;
        check("bp_no_accept_in_out", in_xfers - i0, 0);

        // All-zero vote
        send_vote(20'h00000, 20'h00000, 20'h00000, 20'h00000);
        wait_out("zero_latency");
        take("zero", 4'd0, 4'd0, 0);

        // Abort: two all-3 beats, reset, then class 5 scores 1 per beat
        send_beat(20'hFFFFF);
        send_beat(20'hFFFFF);
        #2 rst_n = 1'b0;
        #1;
        check("abort_reset", {out_valid, in_ready}, 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_vote(20'h00400, 20'h00400, 20'h00400, 20'h00400);
        wait_out("abort_latency");
        take("abort", 4'd5, 4'd4, 0);

        // All classes saturated: tie across every class resolves to 0
        send_vote(20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
        wait_out("max_latency");
        take("max", 4'd0, 4'd12, 0);

        // Back-to-back with in_valid and out_ready held high: class 4 = 8
        i0        = in_xfers;
        o0        = out_xfers;
        in_data   = 20'h00200;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n         = 0;
        while (out_xfers < o0 + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_out_xfers", out_xfers - o0, 2);
        check("b2b_in_xfers", in_xfers - i0, 8);
        check("b2b_cycles", n, 30);
        check("b2b_result", {last_class, last_score}, {4'd4, 4'd8});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
